// File: rtl/fp_unpack_seq.sv
// Sequential IEEE operand unpacker: decodes double/single operands into the wide format and
// normalises denormals with an iterative shifter. Optional class flags under FP_UNPACK_CLASS_EN.
module fp_unpack_seq #(
  parameter int EW   = 11,
  parameter int FW   = 52,
  parameter int SEW  = 8,
  parameter int SFW  = 23,
  parameter int STEP = 8,
  parameter int LZW  = $clog2(FW+1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [EW+FW:0]    fp,
  input  logic              db,
  input  logic              normal,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              s,
  output logic [EW-1:0]     e,
  output logic              e_inf,
  output logic              e_z,
  output logic [FW-1:0]     h,
  output logic [FW:0]       f,
  output logic              fz,
  output logic [LZW-1:0]    lz
`ifdef FP_UNPACK_CLASS_EN
  ,
  output logic              nan,
  output logic              snan,
  output logic              inf,
  output logic              zero,
  output logic              denorm
`endif
);

  localparam int W = EW + FW + 1;
  localparam logic [EW-1:0] BIAS_ADJ = EW'((1 << (EW-1)) - (1 << (SEW-1)));

  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;
  state_t state, state_nxt;

  logic              s_d, e_z_d, e_inf_d, fz_d, go_norm_d, accept;
  logic [EW-1:0]     e_d;
  logic [FW-1:0]     frac_d;
  logic [SEW-1:0]    xs;
  logic [SFW-1:0]    fs;
  logic [STEP-1:0]   top;
  logic              top_zero;
  logic [LZW-1:0]    sh;

  // Single exponent into wide format; a zero field is treated as exponent 1
  function automatic logic [EW-1:0] rebias(input logic [SEW-1:0] x);
    logic [EW-1:0] xm;
    xm = (x == '0) ? EW'(1) : EW'(x);
    return xm + BIAS_ADJ;
  endfunction

  function automatic logic [LZW-1:0] lead_zeros(input logic [STEP-1:0] v);
    logic [LZW-1:0] n;
    logic           hit;
    n   = '0;
    hit = 1'b0;
    for (int i = STEP-1; i >= 0; i--) begin
      if (!hit) begin
        if (v[i]) hit = 1'b1;
        else      n   = n + LZW'(1);
      end
    end
    return n;
  endfunction

  // Decode of the operand presented on the input
  assign xs = fp[W-2 -: SEW];
  assign fs = fp[W-2-SEW -: SFW];

  always_comb begin
    s_d = fp[W-1];
    if (db) begin
      e_z_d   = ~|fp[W-2 -: EW];
      e_inf_d = &fp[W-2 -: EW];
      frac_d  = fp[FW-1:0];
      e_d     = e_z_d ? EW'(1) : fp[W-2 -: EW];
    end else begin
      e_z_d   = ~|xs;
      e_inf_d = &xs;
      frac_d  = {fs, {(FW-SFW){1'b0}}};
      e_d     = e_inf_d ? '1 : rebias(xs);
    end
    fz_d      = ~|frac_d;
    go_norm_d = normal && e_z_d && !fz_d;
  end

  assign accept   = in_valid && in_ready;
  assign top      = f[FW -: STEP];
  assign top_zero = ~|top;
  assign sh       = top_zero ? LZW'(STEP) : lead_zeros(top);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = go_norm_d ? NORM : DONE;
      NORM: if (!top_zero) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = accept ? (go_norm_d ? NORM : DONE) : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = !rst && ((state == IDLE) || (state == DONE && out_ready));
    out_valid = (state == DONE);
  end

  // Result registers: loaded on accept, shifted while normalising
  always_ff @(posedge clk) begin
    if (rst) begin
      s     <= 1'b0;
      e     <= '0;
      e_inf <= 1'b0;
      e_z   <= 1'b0;
      h     <= '0;
      f     <= '0;
      fz    <= 1'b0;
      lz    <= '0;
    end else if (accept) begin
      s     <= s_d;
      e     <= e_d;
      e_inf <= e_inf_d;
      e_z   <= e_z_d;
      h     <= frac_d;
      f     <= {~e_z_d, frac_d};
      fz    <= fz_d;
      lz    <= '0;
    end else if (state == NORM) begin
      f     <= f << sh;
      lz    <= lz + sh;
    end
  end

`ifdef FP_UNPACK_CLASS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      nan    <= 1'b0;
      snan   <= 1'b0;
      inf    <= 1'b0;
      zero   <= 1'b0;
      denorm <= 1'b0;
    end else if (accept) begin
      nan    <= e_inf_d && !fz_d;
      snan   <= e_inf_d && !fz_d && !frac_d[FW-1];
      inf    <= e_inf_d && fz_d;
      zero   <= e_z_d && fz_d;
      denorm <= e_z_d && !fz_d;
    end
  end
`endif

endmodule

// File: doc/fp_unpack_seq.md
# fp_unpack_seq

Sequential, parametrised successor to the FPU's combinational operand unpacker. It accepts one packed IEEE operand per handshake, in double or single format. Single operands are rebiased into the wide exponent format. Denormals are normalised with an iterative multi-cycle shifter, and results are returned over a valid/ready interface. It sits between the operand register file and the FPU add/multiply/divide front ends.

## Interface
- EW, 11: wide exponent width.
- FW, 52: wide fraction width.
- SEW, 8: single exponent width.
- SFW, 23: single fraction width.
- STEP, 8: maximum normalisation shift per cycle, 1..FW.
- LZW, $clog2(FW+1): lz width.
- clk  in  1  clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand valid.
- in_ready  out  1  block can accept an operand this cycle.
- fp  in  EW+FW+1  packed operand; a single operand occupies the top 1+SEW+SFW bits.
- db  in  1  1 = double, 0 = single; sampled with fp.
- normal  in  1  1 = normalise denormal significands; sampled with fp.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- s  out  1  sign.
- e  out  EW  wide-format biased exponent.
- e_inf  out  1  exponent field all ones.
- e_z  out  1  exponent field all zeros.
- h  out  FW  raw fraction; a single fraction is left-aligned and zero-padded.
- f  out  FW+1  significand {hidden, fraction}, normalised when requested.
- fz  out  1  fraction field zero.
- lz  out  LZW  leading-zero count applied to f.

## Operation
- FSM states: IDLE, NORM, DONE.
- in_ready = (state==IDLE) || (state==DONE && out_ready). An operand is accepted when in_valid && in_ready.
- On accept, the block decodes the fields.
  - Double: s = fp[MSB]; exponent x = fp[FW+EW-1:FW]; fraction = fp[FW-1:0].
  - Single: s = fp[MSB]; x = next SEW bits; fraction = next SFW bits, left-aligned into FW.
- e_z = (x==0); e_inf = (x all ones); fz = (fraction==0); hidden = ~e_z.
- Exponent e:
  - Double: e = x, with x==0 mapped to 1.
  - Single with x all ones: e = all ones (EW bits).
  - Single otherwise: e = max(x,1) + 2^(EW-1) - 2^(SEW-1).
- f = {hidden, fraction}; lz = 0.
- After decode:
  - If normal && e_z && !fz: go to NORM.
  - Otherwise: go to DONE.
- NORM performs one step per cycle:
  - If the top STEP bits of f are zero: shift f left by STEP, add STEP to lz, stay in NORM.
  - Otherwise: shift f left by the leading-zero count within the top STEP bits (0..STEP-1), add that count to lz, go to DONE.
- e is never adjusted by lz; the consumer computes e-lz.
- DONE: out_valid = 1 and all outputs are held stable until out_ready.
  - out_ready with a simultaneous accept: the new operand is decoded (back-to-back).
  - out_ready without an accept: go to IDLE.
- A zero operand with normal=1 is not normalised: f=0, lz=0, fz=1.

## Timing
- Reset value of every output and of internal state is 0, with state = IDLE. out_valid = 0. in_ready rises the cycle after rst falls.
- rst asserted in any state, including mid-NORM, discards the in-flight operand at the next edge; no partial result appears.
- Accept at edge k:
  - No normalisation: out_valid is high after edge k, a latency of 1.
  - Denormal with L leading zeros: N = floor(L/STEP)+1 NORM cycles; out_valid is high after edge k+N, a latency of 1+N.
- With out_ready held high, throughput is one operand per cycle for operands that need no normalisation.
- in_ready is low throughout NORM.

## Configuration
- FP_UNPACK_CLASS_EN defined:
  - Adds registered outputs nan, snan, inf, zero, denorm (1 bit each), valid with out_valid and reset to 0.
  - nan = e_inf&!fz; snan = nan & fraction MSB==0; inf = e_inf&fz; zero = e_z&fz; denorm = e_z&!fz.
- FP_UNPACK_CLASS_EN undefined: these ports and their logic are absent; all other behaviour is identical.

## Test plan
- Double 1.0: fp=64'h3FF0000000000000, db=1, normal=1, out_ready=1.
  - Required: after 1 cycle, s=0, e=11'h3FF, f=1<<52, fz=1, lz=0, e_z=0, e_inf=0.
- Single −1.0: fp=64'hBF80000000000000, db=0.
  - Required: s=1, e=11'h3FF, h=0, f=1<<52, fz=1.
- Infinity: fp=64'h7FF0000000000000, db=1.
  - Required: e_inf=1, fz=1, e=11'h7FF; with FP_UNPACK_CLASS_EN, inf=1 and nan=0.
- Smallest denormal: fp=64'h0000000000000001, normal=1, STEP=8.
  - Required: out_valid exactly 8 cycles after accept, lz=52, f=1<<52, e=1, e_z=1, in_ready low during NORM.
  - Same operand with normal=0: latency 1, f=1, lz=0.
- Backpressure: out_ready=0 for 5 cycles.
  - Required: outputs stable, in_ready=0.
  - Then out_ready=1 with in_valid=1 and a new operand: the new result appears on the next cycle.
- Reset mid-NORM: rst pulsed on the 3rd NORM cycle.
  - Required: out_valid=0 and all outputs 0 next cycle, state IDLE, no stale result later.
